// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 8 data bits, optional odd/even parity, one stop bit.
// Each byte is reported with a one-cycle rx_done strobe. Framing and parity errors are flagged with one-cycle pulses.
module uart_rx_os #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [DW-1:0] div_cnt_reg;
    logic        tick;
    logic        sync1_reg, rxs_reg;
    logic [3:0]  scnt_reg, scnt_next;
    logic [2:0]  bcnt_reg, bcnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        par_bad_reg, par_bad_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        done_reg, done_next;
    logic        ferr_reg, ferr_next;
    logic        perr_reg, perr_next;

    // Synchronizer flops preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rxs_reg   <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rxs_reg   <= sync1_reg;
        end
    end

    assign tick = (div_cnt_reg == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            scnt_reg    <= '0;
            bcnt_reg    <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
            rx_data_reg <= '0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            scnt_reg    <= scnt_next;
            bcnt_reg    <= bcnt_next;
            shift_reg   <= shift_next;
            par_bad_reg <= par_bad_next;
            rx_data_reg <= rx_data_next;
            done_reg    <= done_next;
            ferr_reg    <= ferr_next;
            perr_reg    <= perr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        scnt_next    = scnt_reg;
        bcnt_next    = bcnt_reg;
        shift_next   = shift_reg;
        par_bad_next = par_bad_reg;
        rx_data_next = rx_data_reg;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
        perr_next    = 1'b0;
        if (tick) begin
            scnt_next = scnt_reg + 4'd1;
            case (state_reg)
                S_IDLE: begin
                    if (!rxs_reg) begin
                        state_next   = S_START;
                        par_bad_next = 1'b0;
                    end
                end
                S_START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (scnt_reg == 4'd7) begin
                        if (!rxs_reg) begin
                            state_next = S_DATA;
                            bcnt_next  = 3'd0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (scnt_reg == 4'd15) begin
                        shift_next[bcnt_reg] = rxs_reg;
                        bcnt_next            = bcnt_reg + 3'd1;
                        if (bcnt_reg == 3'd7) begin
                            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (scnt_reg == 4'd15) begin
                        par_bad_next = (PARITY == 1) ? ~(^shift_reg ^ rxs_reg)
                                                     : (^shift_reg ^ rxs_reg);
                        state_next   = S_STOP;
                    end
                end
                S_STOP: begin
                    if (scnt_reg == 4'd15) begin
                        if (rxs_reg) begin
                            rx_data_next = shift_reg;
                            done_next    = 1'b1;
                            perr_next    = par_bad_reg;
                            state_next   = S_IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Hold off through a break until the line returns high.
                    if (rxs_reg) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
            if (state_next != state_reg) begin
                scnt_next = 4'd0;
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_done    = done_reg;
    assign frame_err  = ferr_reg;
    assign parity_err = perr_reg;
    assign busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: one receiver without parity and one with even parity, both driven by serial frames built bit by bit.
// The expected bytes, parity flags and error counts are derived from the frame contents.
module tb_uart_rx_os;
    localparam int BIT_CLKS = 432;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       done_a, done_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int ferr_cnt_a = 0;
    int ferr_cnt_b = 0;
    logic prev_done_a = 1'b0, prev_done_b = 1'b0;
    logic prev_ferr_a = 1'b0, prev_ferr_b = 1'b0;
    logic [8:0] got_a[$];
    logic [8:0] got_b[$];

    uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .PARITY(0)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_done(done_a),
        .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a)
    );

    uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .PARITY(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_done(done_b),
        .frame_err(ferr_b), .parity_err(perr_b), .busy(busy_b)
    );

    always #10 clk = ~clk;

    // Record every strobe and catch any pulse that breaks the one-cycle/exclusivity rules.
    always @(negedge clk) begin
        if (done_a) got_a.push_back({perr_a, data_a});
        if (done_b) got_b.push_back({perr_b, data_b});
        if (ferr_a) ferr_cnt_a++;
        if (ferr_b) ferr_cnt_b++;
        if ((done_a && ferr_a) || (done_b && ferr_b) ||
            (perr_a && !done_a) || (perr_b && !done_b) ||
            (done_a && prev_done_a) || (done_b && prev_done_b) ||
            (ferr_a && prev_ferr_a) || (ferr_b && prev_ferr_b))
            viol++;
        prev_done_a = done_a;
        prev_done_b = done_b;
        prev_ferr_a = ferr_a;
        prev_ferr_b = ferr_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                        input logic p, input logic stop);
        drive(sel, 1'b0);
        hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            hold(BIT_CLKS);
        end
        if (use_par) begin
            drive(sel, p);
            hold(BIT_CLKS);
        end
        drive(sel, stop);
        hold(BIT_CLKS);
    endtask

    task automatic expect_frame(input bit sel, input logic [7:0] d, input logic p, input string tag);
        logic [8:0] e;
        logic [8:0] g;
        int avail;
        e = {p, d};
        avail = sel ? got_b.size() : got_a.size();
        check({tag, " avail"}, 32'(avail > 0), 32'(1));
        if (avail > 0) begin
            g = sel ? got_b.pop_front() : got_a.pop_front();
            check({tag, " data"}, 32'(g[7:0]), 32'(e[7:0]));
            check({tag, " perr"}, 32'(g[8]), 32'(e[8]));
        end
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n;
        n = 0;
        while ((sel ? busy_b : busy_a) && n < 12 * BIT_CLKS) begin
            hold(1);
            n++;
        end
        check({tag, " idle"}, 32'(sel ? busy_b : busy_a), 32'(0));
    endtask

    initial begin
        logic [7:0] d;
        logic p;
        @(negedge clk);
        // 1: reset and quiet line
        hold(10);
        check("rst data", 32'(data_a), 32'h00);
        check("rst busy", 32'(busy_a), 32'(0));
        check("rst done", 32'(done_a), 32'(0));
        rst = 1'b0;
        hold(5000);
        check("quiet strobes a", 32'(got_a.size() + ferr_cnt_a), 32'(0));
        check("quiet strobes b", 32'(got_b.size() + ferr_cnt_b), 32'(0));
        check("quiet busy", 32'(busy_a), 32'(0));

        // 2: plain 8N1 frame
        send(0, 8'h55, 0, 1'b0, 1'b1);
        hold(4);
        expect_frame(0, 8'h55, 1'b0, "t2");
        check("t2 ferr", 32'(ferr_cnt_a), 32'(0));
        check("t2 busy", 32'(busy_a), 32'(0));
        check("t2 rx_data", 32'(data_a), 32'h55);

        // 3: short low glitch is rejected
        rx_a = 1'b0;
        hold(100);
        rx_a = 1'b1;
        hold(BIT_CLKS - 100);
        check("t3 busy", 32'(busy_a), 32'(0));
        check("t3 done", 32'(got_a.size()), 32'(0));
        check("t3 ferr", 32'(ferr_cnt_a), 32'(0));

        // 4: bad stop bit followed by a break, then a good frame
        send(0, 8'hA3, 0, 1'b0, 1'b0);
        hold(2 * BIT_CLKS);
        check("t4 ferr", 32'(ferr_cnt_a), 32'(1));
        check("t4 no done", 32'(got_a.size()), 32'(0));
        check("t4 data kept", 32'(data_a), 32'h55);
        check("t4 busy in break", 32'(busy_a), 32'(1));
        rx_a = 1'b1;
        hold(BIT_CLKS);
        send(0, 8'h0F, 0, 1'b0, 1'b1);
        hold(4);
        expect_frame(0, 8'h0F, 1'b0, "t4");
        check("t4 ferr after", 32'(ferr_cnt_a), 32'(1));

        // 5: even parity, wrong then right parity bit
        send(1, 8'h81, 1, 1'b1, 1'b1);
        hold(4);
        expect_frame(1, 8'h81, 1'b1, "t5 bad");
        send(1, 8'h81, 1, 1'b0, 1'b1);
        hold(4);
        expect_frame(1, 8'h81, 1'b0, "t5 good");

        // 6: reset mid-frame, then two frames back to back
        rx_a = 1'b0;
        hold(BIT_CLKS);
        d = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            rx_a = d[i];
            hold(BIT_CLKS);
        end
        rst = 1'b1;
        rx_a = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(2);
        check("t6 rst data", 32'(data_a), 32'h00);
        check("t6 rst busy", 32'(busy_a), 32'(0));
        check("t6 rst no strobe", 32'(got_a.size() + ferr_cnt_a - 1), 32'(0));
        hold(BIT_CLKS);
        send(0, 8'h00, 0, 1'b0, 1'b1);
        send(0, 8'hFF, 0, 1'b0, 1'b1);
        hold(4);
        expect_frame(0, 8'h00, 1'b0, "t6 first");
        expect_frame(0, 8'hFF, 1'b0, "t6 second");

        // Random back-to-back frames, no parity
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            send(0, d, 0, 1'b0, 1'b1);
            hold(2);
            expect_frame(0, d, 1'b0, $sformatf("rnd a%0d", k));
        end
        wait_idle(0, "rnd a");

        // Random even-parity frames with a random parity bit
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            send(1, d, 1, p, 1'b1);
            hold(2);
            expect_frame(1, d, (^d) ^ p, $sformatf("rnd b%0d", k));
        end
        wait_idle(1, "rnd b");

        check("leftover a", 32'(got_a.size()), 32'(0));
        check("leftover b", 32'(got_b.size()), 32'(0));
        check("ferr b", 32'(ferr_cnt_b), 32'(0));
        check("strobe rules", 32'(viol), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
